disp_hex_mux: RTL
=================

DISP_HEX_MUX -- requirements
Module: disp_hex_mux

Interface
REQ-001 Parameter REFRESH_BITS, default 18, width of the free-running refresh counter; each digit slot lasts 2^(REFRESH_BITS-2) cycles.
REQ-002 Parameter BLANK_CYCLES, default 16, number of anode-off cycles at the start of every slot (anti-ghosting); SHALL be less than the slot length.
REQ-003 Parameter LZ_SUPPRESS, default 1, 1 enables leading-zero blanking.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 hex_in  input  16  four nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 dp_in  input  4  decimal points, bit i for digit i, 1 = lit.
REQ-008 load  input  1  one-cycle strobe capturing hex_in/dp_in into the staging register.
REQ-009 an  output  4  digit anode enables, active low, bit i drives digit i.
REQ-010 hex  output  4  nibble of the currently scanned digit, fed to the downstream segment decoder.
REQ-011 dp  output  1  decimal point to the decoder, active low (1 = off).
REQ-012 frame_tick  output  1  one-cycle pulse marking the start of a new 4-digit frame.

Function
REQ-013 Refresh counter increments every cycle and wraps from all-ones to 0; digit index = counter[REFRESH_BITS-1:REFRESH_BITS-2], slot offset = remaining low bits.
REQ-014 Scan order: digits 0, 1, 2, 3, 0, ...
REQ-015 All outputs are registered: they reflect the counter value of the previous cycle (latency 1).
REQ-016 an has exactly one bit low when the slot offset >= BLANK_CYCLES and the indexed digit is not suppressed; otherwise an = 4'b1111.
REQ-017 hex and dp always follow the indexed digit of the active register, including during blanking.
REQ-018 load captures hex_in/dp_in into staging and sets a pending flag; a later load overwrites staging (last write wins).
REQ-019 When the counter wraps to 0 with pending set, staging copies into the active register and pending clears; the display never changes mid-frame.
REQ-020 load asserted in the wrap cycle: the new hex_in/dp_in goes directly to the active register and pending clears.
REQ-021 frame_tick is high for the single output cycle corresponding to counter value 0.
REQ-022 Leading-zero suppression (LZ_SUPPRESS=1): digit i (i = 3..1) is blanked if its nibble and every higher nibble are 0 and none of those digits nor digit i has its dp lit; digit 0 is never suppressed.
REQ-023 LZ_SUPPRESS=0: no digit is suppressed.

Reset
REQ-024 While reset is high at a rising edge: counter = 0, staging = 0, active = 0, pending = 0, an = 4'b1111, hex = 4'h0, dp = 1, frame_tick = 0.
REQ-025 Reset mid-frame or with pending set discards the pending data; scanning restarts from digit 0 on the first cycle after reset deasserts.
REQ-026 load coincident with reset is ignored.

Structure
REQ-027 Shared package disp_pkg holds NUM_DIGITS = 4, AN_ALL_OFF = 4'b1111 and DP_OFF = 1'b1, for use by this block and its display neighbours.
REQ-028 One sub-module, disp_scan_timer, holds the refresh counter and emits digit index, slot offset and the wrap strobe; staging, suppression and output registers remain in disp_hex_mux.
REQ-029 Segment decoding is excluded; hex and dp connect directly to the existing seven-segment decoder.

Verification (REFRESH_BITS=6, slot 16 cycles, BLANK_CYCLES=2)
REQ-030 Reset, then load 16'h1234, dp_in 4'b0000 -> from the next frame: digit 0 slot hex=4, an=1111 for 2 cycles then 1110 for 14 cycles; digits 1..3 show 3, 2, 1 with an 1101, 1011, 0111.
REQ-031 Load 16'h0007 with LZ_SUPPRESS=1 -> digits 3..1 keep an=1111 for the whole slot; digit 0 gives hex=7, an=1110; with LZ_SUPPRESS=0 all four anodes are enabled in turn.
REQ-032 Load 16'h0050, dp_in 4'b0100 -> digit 3 suppressed; digit 2 shows 0 with dp=0; digits 1 and 0 show 5 and 0.
REQ-033 Load 16'hAAAA mid-frame, then 16'hBBBB in the same frame -> the current frame is unchanged and the next frame shows B on all digits; frame_tick pulses once every 64 cycles.
REQ-034 Load 16'hCCCC in the wrap cycle -> the frame starting that cycle shows C; assert reset mid-frame with pending data -> an=1111, dp=1, and after reset deasserts digit 0 shows 0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and types for the seven-segment display blocks.
package disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 4'b1111;
  localparam logic DP_OFF = 1'b1;

  // One displayable frame: a nibble and a decimal point per digit.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] hex;
    logic [NUM_DIGITS-1:0]      dp;
  } disp_word_t;
endpackage

// File: rtl/disp_scan_timer.sv
// Free-running refresh counter; splits into digit index and slot offset.
module disp_scan_timer
  import disp_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [DIG_W-1:0]        digit,
  output logic [REFRESH_BITS-3:0] offset,
  output logic                    wrap
);
  logic [REFRESH_BITS-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + REFRESH_BITS'(1);
  end

  assign digit  = cnt[REFRESH_BITS-1 -: DIG_W];
  assign offset = cnt[REFRESH_BITS-3:0];
  // High in the last cycle of a frame; the counter reads 0 next cycle.
  assign wrap   = &cnt;
endmodule

// File: rtl/disp_hex_mux.sv
// Four-digit multiplexed hex display driver with frame-synchronous updates,
// anti-ghost blanking and optional leading-zero suppression.
module disp_hex_mux
  import disp_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter int BLANK_CYCLES = 16,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           hex_in,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  load,
  output logic [NUM_DIGITS-1:0] an,
  output logic [3:0]            hex,
  output logic                  dp,
  output logic                  frame_tick
);
  localparam int OFS_W = REFRESH_BITS - 2;
  localparam logic [OFS_W-1:0] BLANK_OFS = OFS_W'(BLANK_CYCLES);

  logic [DIG_W-1:0] digit;
  logic [OFS_W-1:0] offset;
  logic             wrap;

  disp_scan_timer #(.REFRESH_BITS(REFRESH_BITS)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .digit  (digit),
    .offset (offset),
    .wrap   (wrap)
  );

  disp_word_t staging, active, in_word;
  logic       pending;

  assign in_word.hex = hex_in;
  assign in_word.dp  = dp_in;

  // Active only changes at the frame boundary so a frame is never torn.
  always_ff @(posedge clk) begin
    if (reset) begin
      staging <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (wrap) begin
      if (load)         active <= in_word;
      else if (pending) active <= staging;
      pending <= 1'b0;
    end else if (load) begin
      staging <= in_word;
      pending <= 1'b1;
    end
  end

  // zero_up[i]: digit i and all higher digits are 0 with no dp lit.
  logic [NUM_DIGITS-1:0] zero_up, supp;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == NUM_DIGITS-1) begin : g_top
        assign zero_up[gi] = (active.hex[gi] == 4'h0) && !active.dp[gi];
      end else begin : g_low
        assign zero_up[gi] = zero_up[gi+1] && (active.hex[gi] == 4'h0) && !active.dp[gi];
      end
      if (gi == 0) begin : g_d0
        assign supp[gi] = 1'b0;
      end else begin : g_dn
        assign supp[gi] = LZ_SUPPRESS && zero_up[gi];
      end
    end
  endgenerate

  logic [NUM_DIGITS-1:0] an_next;
  always_comb begin
    an_next = AN_ALL_OFF;
    if (offset >= BLANK_OFS && !supp[digit]) an_next[digit] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= AN_ALL_OFF;
      hex        <= 4'h0;
      dp         <= DP_OFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      hex        <= active.hex[digit];
      dp         <= ~active.dp[digit];
      frame_tick <= (digit == '0) && (offset == '0);
    end
  end
endmodule
